// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg : shared FSM encoding and synchronizer depth for the serial receiver
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rx_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rx_edge_det.sv
// ---------------------------------------------------------------------------
// edge_det : synchronizer followed by a one-cycle rising-edge pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_det
  import rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync;
  logic                  prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], d};
      prev <= sync[SYNC_DEPTH-1];
    end
  end

  assign rise = sync[SYNC_DEPTH-1] & ~prev;

endmodule

`default_nettype wire

// File: rtl/rx.sv
// ---------------------------------------------------------------------------
// rx : oversampling serial receiver (MSB first) with framing/overrun flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx
  import rx_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int NB_STOP    = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  clk_rx,
  input  logic                  i_buf,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_rdy,
  input  logic                  i_re,
  output logic                  o_ferr,
  output logic                  o_ovr
);

  localparam int BIT_MAX = (WIDTH_DATA > NB_STOP) ? WIDTH_DATA : NB_STOP;
  localparam int BW      = $clog2(BIT_MAX + 1);
  localparam int OW      = $clog2(OVERSAMPLE);

  localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH_DATA - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(NB_STOP - 1);

  logic                  tick;
  logic [SYNC_DEPTH-1:0] line_sync;
  logic                  line;

  state_t                state, state_nxt;
  logic [OW-1:0]         os_cnt, os_cnt_nxt;
  logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
  logic [WIDTH_DATA-1:0] shift, shift_nxt;
  logic                  ferr_acc, ferr_acc_nxt;
  logic                  done;

  edge_det u_tick (
    .clk   (i_clk),
    .rst_n (i_nrst),
    .d     (clk_rx),
    .rise  (tick)
  );

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) line_sync <= '1;
    else         line_sync <= {line_sync[SYNC_DEPTH-2:0], i_buf};
  end

  assign line = line_sync[SYNC_DEPTH-1];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state    <= IDLE;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      ferr_acc <= 1'b0;
    end else begin
      state    <= state_nxt;
      os_cnt   <= os_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      ferr_acc <= ferr_acc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    os_cnt_nxt   = os_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    ferr_acc_nxt = ferr_acc;
    done         = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!line) begin
            state_nxt  = START;
            os_cnt_nxt = '0;
          end
        end
        START: begin
          if (os_cnt == OS_MID) begin
            os_cnt_nxt   = '0;
            bit_cnt_nxt  = '0;
            ferr_acc_nxt = 1'b0;
            state_nxt    = line ? IDLE : DATA;
          end else begin
            os_cnt_nxt = os_cnt + OW'(1);
          end
        end
        DATA: begin
          if (os_cnt == OS_LAST) begin
            os_cnt_nxt = '0;
            shift_nxt  = {shift[WIDTH_DATA-2:0], line};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt_nxt = '0;
              state_nxt   = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + BW'(1);
            end
          end else begin
            os_cnt_nxt = os_cnt + OW'(1);
          end
        end
        STOP: begin
          if (os_cnt == OS_LAST) begin
            os_cnt_nxt = '0;
            if (!line) ferr_acc_nxt = 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt_nxt = '0;
              state_nxt   = IDLE;
              done        = 1'b1;
            end else begin
              bit_cnt_nxt = bit_cnt + BW'(1);
            end
          end else begin
            os_cnt_nxt = os_cnt + OW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Completion takes priority over a coincident read strobe.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_data <= '0;
      o_rdy  <= 1'b0;
      o_ferr <= 1'b0;
      o_ovr  <= 1'b0;
    end else if (done) begin
      o_data <= shift;
      o_ferr <= ferr_acc_nxt;
      o_ovr  <= o_rdy;
      o_rdy  <= 1'b1;
    end else if (i_re) begin
      o_rdy  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx.sv
// ---------------------------------------------------------------------------
// tb_rx : directed, table-driven bench for the rx serial receiver
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rx;

  logic       i_clk  = 1'b0;
  logic       i_nrst = 1'b0;
  logic       clk_rx = 1'b0;
  logic       i_buf  = 1'b1;
  logic       i_re   = 1'b0;
  logic [7:0] o_data;
  logic       o_rdy;
  logic       o_ferr;
  logic       o_ovr;

  int n_vec = 0;
  int n_err = 0;

  rx #(.WIDTH_DATA(8), .NB_STOP(2), .OVERSAMPLE(16)) dut (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .clk_rx (clk_rx),
    .i_buf  (i_buf),
    .o_data (o_data),
    .o_rdy  (o_rdy),
    .i_re   (i_re),
    .o_ferr (o_ferr),
    .o_ovr  (o_ovr)
  );

  always #5  i_clk  = ~i_clk;
  always #20 clk_rx = ~clk_rx;

  typedef struct {
    logic [7:0] d;
    logic       s1;
    logic       s2;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int nticks);
    i_buf = v;
    repeat (nticks) @(posedge clk_rx);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic s1, input logic s2);
    hold(1'b0, 16);
    for (int i = 7; i >= 0; i--) hold(d[i], 16);
    hold(s1, 16);
    hold(s2, 16);
    i_buf = 1'b1;
  endtask

  task automatic settle();
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  task automatic read_pulse();
    @(posedge i_clk); #1 i_re = 1'b1;
    @(posedge i_clk); #1 i_re = 1'b0;
  endtask

  initial begin
    vecs[0] = '{d: 8'hA5, s1: 1'b1, s2: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{d: 8'h3C, s1: 1'b0, s2: 1'b1, exp_data: 8'h3C, exp_ferr: 1'b1};
    vecs[2] = '{d: 8'h5A, s1: 1'b1, s2: 1'b1, exp_data: 8'h5A, exp_ferr: 1'b0};
    vecs[3] = '{d: 8'h00, s1: 1'b0, s2: 1'b1, exp_data: 8'h00, exp_ferr: 1'b1};
    vecs[4] = '{d: 8'hFF, s1: 1'b1, s2: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};

    repeat (3) @(posedge i_clk);
    #1;
    check("reset_data", o_data, 8'h00);
    check("reset_rdy",  o_rdy,  1'b0);
    check("reset_ferr", o_ferr, 1'b0);
    check("reset_ovr",  o_ovr,  1'b0);
    @(negedge i_clk) i_nrst = 1'b1;
    hold(1'b1, 8);

    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].d, vecs[v].s1, vecs[v].s2);
      settle();
      check($sformatf("vec%0d_rdy", v),  o_rdy,  1'b1);
      check($sformatf("vec%0d_data", v), o_data, vecs[v].exp_data);
      check($sformatf("vec%0d_ferr", v), o_ferr, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v),  o_ovr,  1'b0);
      read_pulse();
      check($sformatf("vec%0d_rdy_after_read", v), o_rdy, 1'b0);
      hold(1'b1, 4);
    end

    // Short start pulse must be rejected; a clean frame afterwards still works.
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("glitch_rdy", o_rdy, 1'b0);
    send_frame(8'h42, 1'b1, 1'b1);
    settle();
    check("post_glitch_rdy",  o_rdy,  1'b1);
    check("post_glitch_data", o_data, 8'h42);
    check("post_glitch_ferr", o_ferr, 1'b0);
    read_pulse();
    hold(1'b1, 4);

    // Back-to-back frames with no read in between.
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    settle();
    check("ovr_rdy",  o_rdy,  1'b1);
    check("ovr_data", o_data, 8'h22);
    check("ovr_flag", o_ovr,  1'b1);
    check("ovr_ferr", o_ferr, 1'b0);
    read_pulse();
    check("ovr_read_rdy",  o_rdy, 1'b0);
    check("ovr_read_flag", o_ovr, 1'b1);
    hold(1'b1, 4);

    // Reset in the middle of 0xFF, then a clean 0x81.
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) hold(1'b1, 16);
    hold(1'b1, 8);
    @(negedge i_clk) i_nrst = 1'b0;
    #1;
    check("midrst_rdy_async", o_rdy, 1'b0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_nrst = 1'b1;
    hold(1'b1, 16 * 6);
    check("midrst_no_word_rdy",  o_rdy,  1'b0);
    check("midrst_no_word_data", o_data, 8'h00);
    send_frame(8'h81, 1'b1, 1'b1);
    settle();
    check("midrst_rdy",  o_rdy,  1'b1);
    check("midrst_data", o_data, 8'h81);
    check("midrst_ferr", o_ferr, 1'b0);
    check("midrst_ovr",  o_ovr,  1'b0);
    read_pulse();
    hold(1'b1, 4);

    // Read strobe held across the completion cycle: completion must win.
    i_re = 1'b1;
    fork
      send_frame(8'hC3, 1'b1, 1'b1);
      begin : waiter
        int k;
        k = 0;
        while (o_rdy !== 1'b1 && k < 4000) begin
          @(posedge i_clk);
          #1;
          k++;
        end
        i_re = 1'b0;
        check("re_at_done_rise", o_rdy, 1'b1);
      end
    join
    settle();
    check("re_at_done_rdy",  o_rdy,  1'b1);
    check("re_at_done_data", o_data, 8'hC3);
    check("re_at_done_ovr",  o_ovr,  1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
